// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter: latches a sample on en_out and shifts it MSB-first over sync_n/sclk/sdata.
// Optional macro DAC_TX_CTRL_EN prepends the 4 ctrl bits to each frame.
module dac_serial_tx #(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [3:0]        ctrl,
  output logic              sclk,
  output logic              sync_n,
  output logic              sdata,
  output logic              busy,
  output logic              done,
  output logic              ovr
);

`ifdef DAC_TX_CTRL_EN
  localparam int FRAME_W = DATA_W + 4;
  logic [FRAME_W-1:0] frame;
  assign frame = {ctrl, data_in};
`else
  localparam int FRAME_W = DATA_W;
  logic [FRAME_W-1:0] frame;
  logic               ctrl_unused;
  assign frame       = data_in;
  assign ctrl_unused = ^ctrl;
`endif

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]         state;
  logic [FRAME_W-1:0] shift_reg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               low_phase;
  logic               div_last;

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

  // low_phase tracks which sclk half-period the divider is timing within a bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      low_phase <= 1'b0;
      sclk      <= 1'b1;
      sync_n    <= 1'b1;
      sdata     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      done <= 1'b0;
      ovr  <= 1'b0;
      case (state)
        IDLE: begin
          if (en_out) begin
            shift_reg <= frame;
            sdata     <= frame[FRAME_W-1];
            sync_n    <= 1'b0;
            sclk      <= 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= BIT_W'(FRAME_W - 1);
            div_cnt   <= '0;
            low_phase <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          ovr <= en_out;
          if (!div_last) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!low_phase) begin
              sclk      <= 1'b0;
              low_phase <= 1'b1;
            end else if (bit_cnt == '0) begin
              sclk      <= 1'b1;
              sync_n    <= 1'b1;
              sdata     <= 1'b0;
              low_phase <= 1'b0;
              shift_reg <= '0;
              state     <= HOLD;
            end else begin
              // next bit appears together with the rising sclk edge
              bit_cnt   <= bit_cnt - BIT_W'(1);
              shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
              sdata     <= shift_reg[FRAME_W-2];
              sclk      <= 1'b1;
              low_phase <= 1'b0;
            end
          end
        end
        HOLD: begin
          ovr <= en_out;
          if (!div_last) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Self-checking bench for dac_serial_tx: two instances (CLK_DIV=4 and CLK_DIV=1),
// a serial-capture monitor and a queue scoreboard of expected frames.
module tb_dac_serial_tx;
  localparam int DATA_W = 12;
`ifdef DAC_TX_CTRL_EN
  localparam int FW = DATA_W + 4;
`else
  localparam int FW = DATA_W;
`endif
  localparam int LAT0 = (2 * FW + 1) * 4;
  localparam int LAT1 = (2 * FW + 1) * 1;

  typedef logic [FW-1:0] frame_t;

  typedef struct {
    int               inst;
    logic [DATA_W-1:0] data;
    logic [3:0]        ctrl;
    frame_t            exp_frame;
    int                exp_lat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en_out  [2];
  logic [DATA_W-1:0] data_in [2];
  logic [3:0]        ctrl    [2];
  logic              sclk    [2];
  logic              sync_n  [2];
  logic              sdata   [2];
  logic              busy    [2];
  logic              done    [2];
  logic              ovr     [2];

  int checks = 0;
  int errors = 0;

  frame_t q0[$];
  frame_t q1[$];

  always #5 clk = ~clk;

  dac_serial_tx #(.DATA_W(DATA_W), .CLK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .en_out(en_out[0]), .data_in(data_in[0]), .ctrl(ctrl[0]),
    .sclk(sclk[0]), .sync_n(sync_n[0]), .sdata(sdata[0]), .busy(busy[0]),
    .done(done[0]), .ovr(ovr[0])
  );

  dac_serial_tx #(.DATA_W(DATA_W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en_out(en_out[1]), .data_in(data_in[1]), .ctrl(ctrl[1]),
    .sclk(sclk[1]), .sync_n(sync_n[1]), .sdata(sdata[1]), .busy(busy[1]),
    .done(done[1]), .ovr(ovr[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t modelFrame(input logic [3:0] c, input logic [DATA_W-1:0] d);
`ifdef DAC_TX_CTRL_EN
    return {c, d};
`else
    return d;
`endif
  endfunction

  // Monitor: sdata captured on each sclk fall inside the frame, scored when sync_n rises
  int     mcnt  [2] = '{0, 0};
  frame_t mword [2] = '{'0, '0};
  logic   psclk [2] = '{1'b1, 1'b1};
  logic   psync [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mcnt[i]  = 0;
        mword[i] = '0;
        psclk[i] = 1'b1;
        psync[i] = 1'b1;
      end else begin
        if (psclk[i] && !sclk[i] && !sync_n[i]) begin
          mword[i] = {mword[i][FW-2:0], sdata[i]};
          mcnt[i]++;
        end
        if (!psync[i] && sync_n[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_unexpected inst %0d: got %0h expected no frame", i, mword[i]);
          end else begin
            frame_t e;
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("frame_word inst%0d", i), 32'(mword[i]), 32'(e));
            checkOutput($sformatf("frame_bits inst%0d", i), 32'(mcnt[i]), 32'(FW));
          end
          mcnt[i]  = 0;
          mword[i] = '0;
        end
        psclk[i] = sclk[i];
        psync[i] = sync_n[i];
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [DATA_W-1:0] d, input logic [3:0] c,
                               input frame_t e);
    data_in[i] = d;
    ctrl[i]    = c;
    en_out[i]  = 1'b1;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    en_out[i] = 1'b0;
  endtask

  // Called right after the accepting edge; strobes at s1/s2 should only raise ovr
  task automatic waitDone(input int i, input int exp_n, input int s1, input int s2,
                          input int exp_ovr, input string name);
    int n = 0;
    int done_n = -1;
    int busy_bad = 0;
    int ovr_cnt = 0;
    while (1) begin
      if (ovr[i]) ovr_cnt++;
      if (done[i]) begin
        done_n = n;
        if (busy[i]) busy_bad++;
        break;
      end
      if (!busy[i]) busy_bad++;
      en_out[i] = (n == s1 || n == s2);
      if (n >= exp_n + 10) break;
      @(negedge clk);
      n++;
    end
    en_out[i] = 1'b0;
    checkOutput({name, "_done_time"}, 32'(done_n), 32'(exp_n));
    checkOutput({name, "_busy_window"}, 32'(busy_bad), 32'd0);
    checkOutput({name, "_ovr_pulses"}, 32'(ovr_cnt), 32'(exp_ovr));
  endtask

  vec_t vecs[5];
  frame_t trash;
  int done_seen;

  initial begin
`ifdef DAC_TX_CTRL_EN
    vecs[0] = '{0, 12'hA5C, 4'h3, 16'h3A5C, LAT0};
    vecs[1] = '{1, 12'hFFF, 4'h0, 16'h0FFF, LAT1};
    vecs[2] = '{1, 12'h000, 4'hF, 16'hF000, LAT1};
    vecs[3] = '{0, 12'h800, 4'h3, 16'h3800, 132};
    vecs[4] = '{0, 12'h3C3, 4'hA, 16'hA3C3, LAT0};
`else
    vecs[0] = '{0, 12'hA5C, 4'h3, 12'hA5C, 100};
    vecs[1] = '{1, 12'hFFF, 4'h0, 12'hFFF, 25};
    vecs[2] = '{1, 12'h000, 4'hF, 12'h000, 25};
    vecs[3] = '{0, 12'h800, 4'h3, 12'h800, LAT0};
    vecs[4] = '{0, 12'h3C3, 4'hA, 12'h3C3, LAT0};
`endif
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en_out[i]  = 1'b0;
      data_in[i] = '0;
      ctrl[i]    = '0;
    end
    repeat (2) @(negedge clk);
    checkOutput("rst_sclk", 32'(sclk[0]), 32'd1);
    checkOutput("rst_sync_n", 32'(sync_n[0]), 32'd1);
    checkOutput("rst_sdata", 32'(sdata[0]), 32'd0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_done", 32'(done[0]), 32'd0);
    checkOutput("rst_ovr", 32'(ovr[0]), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Abort a frame mid-SHIFT; its expectation is withdrawn before reset hits
    applyStimulus(0, 12'h3C3, 4'h5, modelFrame(4'h5, 12'h3C3));
    repeat (30) @(negedge clk);
    trash = q0.pop_back();
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_sclk", 32'(sclk[0]), 32'd1);
    checkOutput("abort_sync_n", 32'(sync_n[0]), 32'd1);
    checkOutput("abort_sdata", 32'(sdata[0]), 32'd0);
    checkOutput("abort_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    done_seen = 0;
    for (int k = 0; k < LAT0 + 20; k++) begin
      if (done[0] || busy[0]) done_seen++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].inst, vecs[v].data, vecs[v].ctrl, vecs[v].exp_frame);
      waitDone(vecs[v].inst, vecs[v].exp_lat, -1, -1, 0, $sformatf("vec%0d", v));
      repeat (2) @(negedge clk);
    end

    // Strobes during SHIFT and HOLD are refused; a strobe in the done cycle is taken
    applyStimulus(0, 12'h5A5, 4'h6, modelFrame(4'h6, 12'h5A5));
    data_in[0] = 12'hFFF;
    waitDone(0, LAT0, 10, 99, 2, "ovr_seq");
    applyStimulus(0, 12'h123, 4'h9, modelFrame(4'h9, 12'h123));
    checkOutput("back2back_sync_n", 32'(sync_n[0]), 32'd0);
    checkOutput("back2back_ovr", 32'(ovr[0]), 32'd0);
    waitDone(0, LAT0, -1, -1, 0, "back2back");

    repeat (5) @(negedge clk);
    checkOutput("q0_empty", 32'(q0.size()), 32'd0);
    checkOutput("q1_empty", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
